// File: rtl/i2c_target_rx.sv
// i2c_target_rx
// I2C target (slave) receiver. Oversamples SCL/SDA on PCLK, detects START and
// STOP, matches a 7-bit write address, ACKs the address and data bytes and
// stores received bytes in a small FIFO that the host drains with rd_pop.
//
// Optional feature: define I2C_TARGET_GEN_CALL_EN to also answer the general
// call address byte 8'h00. Without it, 8'h00 is a non-matching address.
//
// Ports:
//   PCLK          system clock (at least 4x SCL)
//   PRESETn       asynchronous active-low reset
//   scl_in        bus SCL level
//   sda_in        bus SDA level
//   sda_pull_low  1 = drive SDA low (open-drain), 0 = release
//   rd_pop        pop the FIFO head when rx_valid=1
//   rd_data       FIFO head byte (0 when empty)
//   rx_valid      FIFO not empty
//   rx_full       FIFO full
//   busy          1 from START until STOP
//   addr_hit      one-cycle pulse on an address match with R/W=0
//   overrun       sticky, set when a byte is dropped on a full FIFO
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h78,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         FILT_LEN    = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_pull_low,
  input  logic       rd_pop,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       busy,
  output logic       addr_hit,
  output logic       overrun
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_DATA_ACK = 3'd4;
  localparam logic [2:0] ST_IGNORE   = 3'd5;

  // True when the completed address byte selects this target for a write.
  function automatic logic addr_match(input logic [7:0] b);
`ifdef I2C_TARGET_GEN_CALL_EN
    addr_match = (b == {TARGET_ADDR, 1'b0}) || (b == 8'h00);
`else
    addr_match = (b == {TARGET_ADDR, 1'b0});
`endif
  endfunction

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic [FILT_LEN-1:0] scl_sync_q;
  logic [FILT_LEN-1:0] sda_sync_q;
  logic                scl_prev_q;
  logic                sda_prev_q;
  logic                scl_s;
  logic                sda_s;
  logic                scl_rise_s;
  logic                scl_fall_s;
  logic                start_s;
  logic                stop_s;

  // Synchroniser chains plus one extra sample for edge detection. Reset to the
  // idle bus level so leaving reset never looks like an edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      scl_sync_q <= {FILT_LEN{1'b1}};
      sda_sync_q <= {FILT_LEN{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[FILT_LEN-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[FILT_LEN-2:0], sda_in};
      scl_prev_q <= scl_sync_q[FILT_LEN-1];
      sda_prev_q <= sda_sync_q[FILT_LEN-1];
    end
  end

  assign scl_s      = scl_sync_q[FILT_LEN-1];
  assign sda_s      = sda_sync_q[FILT_LEN-1];
  assign scl_rise_s = scl_s & ~scl_prev_q;
  assign scl_fall_s = ~scl_s & scl_prev_q;
  // SCL must be high in both samples so an SDA change next to an SCL edge
  // is not mistaken for a bus condition.
  assign start_s    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_s     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // ---------------------------------------------------------------------
  // FIFO status
  // ---------------------------------------------------------------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [PW:0] wr_ptr_q;
  logic [PW:0] rd_ptr_q;
  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic        pop_s;
  logic        can_push_s;
  logic        push_s;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pop_s        = rd_pop & ~fifo_empty_s;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign can_push_s   = ~fifo_full_s | pop_s;

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  logic [2:0] state_q,     state_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [6:0] shift_q,     shift_d;
  logic       ack_en_q,    ack_en_d;
  logic       ack_phase_q, ack_phase_d;
  logic       pull_q,      pull_d;
  logic       busy_q,      busy_d;
  logic       hit_q,       hit_d;
  logic       ovr_q,       ovr_d;
  logic [7:0] byte_s;

  // The byte as it stands once the current SDA sample is shifted in.
  assign byte_s = {shift_q, sda_s};

  // Next-state logic; bus conditions override whatever the state is doing.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ack_en_d    = ack_en_q;
    ack_phase_d = ack_phase_q;
    pull_d      = pull_q;
    busy_d      = busy_q;
    hit_d       = 1'b0;
    ovr_d       = ovr_q;
    push_s      = 1'b0;

    if (stop_s) begin
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      pull_d    = 1'b0;
      bit_cnt_d = 3'd0;
    end else if (start_s) begin
      state_d   = ST_ADDR;
      busy_d    = 1'b1;
      pull_d    = 1'b0;
      bit_cnt_d = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d = byte_s[6:0];
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d   = 3'd0;
              ack_phase_d = 1'b0;
              if (addr_match(byte_s)) begin
                state_d  = ST_ADDR_ACK;
                hit_d    = 1'b1;
                ack_en_d = 1'b1;
              end else begin
                state_d  = ST_IGNORE;
                ack_en_d = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        // First SCL fall after bit 8 starts the ACK drive, the second one
        // (end of the 9th clock) releases SDA.
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall_s) begin
            if (!ack_phase_q) begin
              pull_d      = ack_en_q;
              ack_phase_d = 1'b1;
            end else begin
              pull_d      = 1'b0;
              ack_phase_d = 1'b0;
              state_d     = ST_DATA;
              bit_cnt_d   = 3'd0;
            end
          end else begin
            pull_d = pull_q;
          end
        end
        ST_DATA: begin
          if (scl_rise_s) begin
            shift_d = byte_s[6:0];
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d   = 3'd0;
              ack_phase_d = 1'b0;
              state_d     = ST_DATA_ACK;
              if (can_push_s) begin
                push_s   = 1'b1;
                ack_en_d = 1'b1;
              end else begin
                ovr_d    = 1'b1;
                ack_en_d = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ST_IGNORE: begin
          state_d = ST_IGNORE;
        end
        default: begin
          state_d = ST_IDLE;
          pull_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // FSM state and registered bus-side outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      ack_en_q    <= 1'b0;
      ack_phase_q <= 1'b0;
      pull_q      <= 1'b0;
      busy_q      <= 1'b0;
      hit_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ack_en_q    <= ack_en_d;
      ack_phase_q <= ack_phase_d;
      pull_q      <= pull_d;
      busy_q      <= busy_d;
      hit_q       <= hit_d;
      ovr_q       <= ovr_d;
    end
  end

  // FIFO storage and pointers; on push+pop when full the head is read out
  // combinationally this cycle before its slot is overwritten.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q[PW-1:0]] <= byte_s;
        wr_ptr_q                <= wr_ptr_q + (PW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      end
    end
  end

  assign sda_pull_low = pull_q;
  assign busy         = busy_q;
  assign addr_hit     = hit_q;
  assign overrun      = ovr_q;
  assign rx_valid     = ~fifo_empty_s;
  assign rx_full      = fifo_full_s;
  assign rd_data      = fifo_empty_s ? 8'd0 : mem_q[rd_ptr_q[PW-1:0]];

endmodule
